// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ssd_pkg
// Purpose  : Shared constants for the seven-segment scan controller.
//            Contains the active-low segment patterns, the dark values for the
//            anode and cathode buses, and the scan state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package ssd_pkg;

   // Dark values for the active-low cathode and anode buses
   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

   // Scan state: SHOW drives the digit, BLANK is the optional dead time
   typedef enum logic [0:0] {
      SHOW  = 1'b0,
      BLANK = 1'b1
   } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/ssd_hex_decode.sv
`default_nettype none
// ============================================================================
// Module   : ssd_hex_decode
// Purpose  : Combinational 4-bit hex to 7-segment active-low decoder.
// Revision : 1.0 - initial release
// ============================================================================
module ssd_hex_decode
   import ssd_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   // Table lookup of the nibble into its cathode pattern
   always_comb begin
      seg = SEG_OFF;
      case (hex)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_OFF;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ssd_scan_ctrl
// Purpose  : Time-multiplexed scan controller for an 8-digit common-anode
//            seven-segment bank. Walks a one-hot active-low anode, drives the
//            matching nibble's pattern and snapshots the display word once per
//            frame so digits never tear.
// Options  : SSD_SCAN_BLANK_EN - when defined, the last BLANK_CYCLES cycles of
//            every digit slot are dark (anti-ghosting dead time).
// Revision : 1.0 - initial release
// ============================================================================
module ssd_scan_ctrl
   import ssd_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int NUM_DIGITS   = 8,
   parameter int BLANK_CYCLES = 1000
)
(
   input  logic        ssd_scan_ctrl_clk,
   input  logic        ssd_scan_ctrl_rst,
   input  logic        ssd_scan_ctrl_en,
   input  logic [31:0] ssd_scan_ctrl_data,
   input  logic [7:0]  ssd_scan_ctrl_dp,
   input  logic [7:0]  ssd_scan_ctrl_mask,
   output logic [7:0]  ssd_scan_ctrl_an,
   output logic [6:0]  ssd_scan_ctrl_cc,
   output logic        ssd_scan_ctrl_dp_out,
   output logic [2:0]  ssd_scan_ctrl_idx,
   output logic        ssd_scan_ctrl_frame_done
);

   localparam int             DIV_W     = $clog2(REFRESH_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_BLANK = DIV_W'(REFRESH_DIV - 1 - BLANK_CYCLES);
   localparam logic [2:0]     IDX_LAST  = 3'(NUM_DIGITS - 1);

`ifdef SSD_SCAN_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   logic [1:0]       rst_sync;
   logic             rst_int;
   logic [DIV_W-1:0] div_cnt;
   logic [2:0]       digit_idx;
   logic             load_pending;
   logic [31:0]      snap_data;
   logic [7:0]       snap_dp;
   logic [7:0]       snap_mask;
   scan_state_t      state_q;
   scan_state_t      state_d;
   logic             tick;
   logic             frame_wrap;
   logic             snap_load;
   logic             lit;
   logic [6:0]       seg;
   logic [7:0]       an_q;
   logic [6:0]       cc_q;
   logic             dp_q;
   logic             frame_done_q;

   // Reset asserts immediately and releases two clocks later, on a clock edge
   always_ff @(posedge ssd_scan_ctrl_clk or posedge ssd_scan_ctrl_rst) begin
      if (ssd_scan_ctrl_rst) rst_sync <= 2'b11;
      else                   rst_sync <= {rst_sync[0], 1'b0};
   end
   assign rst_int = rst_sync[1];

   assign tick       = ssd_scan_ctrl_en & (div_cnt == DIV_LAST);
   assign frame_wrap = tick & (digit_idx == IDX_LAST);
   assign snap_load  = ssd_scan_ctrl_en & (load_pending | frame_wrap);

   // Slot divider, digit index and end-of-frame pulse
   always_ff @(posedge ssd_scan_ctrl_clk or posedge rst_int) begin
      if (rst_int) begin
         div_cnt      <= '0;
         digit_idx    <= 3'd0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= frame_wrap;
         if (ssd_scan_ctrl_en) div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) digit_idx <= (digit_idx == IDX_LAST) ? 3'd0 : digit_idx + 3'd1;
      end
   end

   // Frame snapshot: first enabled cycle after reset, then at each frame wrap
   always_ff @(posedge ssd_scan_ctrl_clk or posedge rst_int) begin
      if (rst_int) begin
         load_pending <= 1'b1;
         snap_data    <= '0;
         snap_dp      <= '0;
         snap_mask    <= '0;
      end else begin
         if (ssd_scan_ctrl_en) load_pending <= 1'b0;
         if (snap_load) begin
            snap_data <= ssd_scan_ctrl_data;
            snap_dp   <= ssd_scan_ctrl_dp;
            snap_mask <= ssd_scan_ctrl_mask;
         end
      end
   end

   // Scan state register
   always_ff @(posedge ssd_scan_ctrl_clk or posedge rst_int) begin
      if (rst_int) state_q <= SHOW;
      else         state_q <= state_d;
   end

   // Next-state: dead time starts BLANK_CYCLES before the slot end, ends on tick
   always_comb begin
      state_d = state_q;
      case (state_q)
         SHOW:    if (BLANK_EN && ssd_scan_ctrl_en && (div_cnt == DIV_BLANK) && !tick)
                     state_d = BLANK;
         BLANK:   if (tick) state_d = SHOW;
         default: state_d = SHOW;
      endcase
   end

   ssd_hex_decode u_hex_decode (
      .hex (snap_data[{digit_idx, 2'b00} +: 4]),
      .seg (seg)
   );

   assign lit = ssd_scan_ctrl_en & (state_q == SHOW) & snap_mask[digit_idx];

   // Registered pin drivers; masked, blanked or disabled slots stay dark
   always_ff @(posedge ssd_scan_ctrl_clk or posedge rst_int) begin
      if (rst_int) begin
         an_q <= AN_OFF;
         cc_q <= SEG_OFF;
         dp_q <= 1'b1;
      end else begin
         an_q <= lit ? ~(8'd1 << digit_idx) : AN_OFF;
         cc_q <= lit ? seg : SEG_OFF;
         dp_q <= lit ? ~snap_dp[digit_idx] : 1'b1;
      end
   end

   assign ssd_scan_ctrl_an         = an_q;
   assign ssd_scan_ctrl_cc         = cc_q;
   assign ssd_scan_ctrl_dp_out     = dp_q;
   assign ssd_scan_ctrl_idx        = digit_idx;
   assign ssd_scan_ctrl_frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssd_scan_ctrl
// Purpose  : Self-checking bench for ssd_scan_ctrl, 8-digit and 4-digit builds
//            compared against a position-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_ctrl;

   localparam int RD = 4;
   localparam int BC = 1;
`ifdef SSD_SCAN_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [31:0] data = '0;
   logic [7:0]  dp = '0;
   logic [7:0]  mask = '0;

   logic [7:0] an8, an4;
   logic [6:0] cc8, cc4;
   logic       dpo8, dpo4, fd8, fd4;
   logic [2:0] idx8, idx4;

   int total = 0;
   int passed = 0;

   ssd_scan_ctrl #(.REFRESH_DIV(RD), .NUM_DIGITS(8), .BLANK_CYCLES(BC)) dut8 (
      .ssd_scan_ctrl_clk(clk), .ssd_scan_ctrl_rst(rst), .ssd_scan_ctrl_en(en),
      .ssd_scan_ctrl_data(data), .ssd_scan_ctrl_dp(dp), .ssd_scan_ctrl_mask(mask),
      .ssd_scan_ctrl_an(an8), .ssd_scan_ctrl_cc(cc8), .ssd_scan_ctrl_dp_out(dpo8),
      .ssd_scan_ctrl_idx(idx8), .ssd_scan_ctrl_frame_done(fd8));

   ssd_scan_ctrl #(.REFRESH_DIV(RD), .NUM_DIGITS(4), .BLANK_CYCLES(BC)) dut4 (
      .ssd_scan_ctrl_clk(clk), .ssd_scan_ctrl_rst(rst), .ssd_scan_ctrl_en(en),
      .ssd_scan_ctrl_data(data), .ssd_scan_ctrl_dp(dp), .ssd_scan_ctrl_mask(mask),
      .ssd_scan_ctrl_an(an4), .ssd_scan_ctrl_cc(cc4), .ssd_scan_ctrl_dp_out(dpo4),
      .ssd_scan_ctrl_idx(idx4), .ssd_scan_ctrl_frame_done(fd4));

   always #5 clk = ~clk;

   // Reference model: pos counts enabled cycles since reset
   typedef struct {
      int          pos;
      bit          lp;
      logic [31:0] sd;
      logic [7:0]  sdp;
      logic [7:0]  smask;
      logic [7:0]  an;
      logic [6:0]  cc;
      logic        dpo;
      logic        fd;
      int          idx;
   } mdl_t;

   mdl_t m8, m4;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      hex7 = 7'h7F;
      case (n)
         4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;  4'hF: hex7 = 7'b0001110;
         default: hex7 = 7'h7F;
      endcase
   endfunction

   function automatic mdl_t mreset();
      mdl_t m;
      m.pos = 0; m.lp = 1'b1; m.sd = '0; m.sdp = '0; m.smask = '0;
      m.an = 8'hFF; m.cc = 7'h7F; m.dpo = 1'b1; m.fd = 1'b0; m.idx = 0;
      return m;
   endfunction

   // One clock edge: outputs follow the slot the position was in before the edge
   function automatic mdl_t mstep(input mdl_t m_in, input int nd, input logic e,
                                  input logic [31:0] d, input logic [7:0] p, input logic [7:0] k);
      mdl_t m;
      int   fl, dv, ix;
      bit   blank, lit, last;
      m     = m_in;
      fl    = RD * nd;
      dv    = m.pos % RD;
      ix    = (m.pos / RD) % nd;
      last  = (m.pos % fl) == (fl - 1);
      blank = BLANK_EN && (dv >= RD - BC);
      lit   = e && !blank && m.smask[ix];
      m.an  = lit ? ~(8'd1 << ix) : 8'hFF;
      m.cc  = lit ? hex7(m.sd[ix*4 +: 4]) : 7'h7F;
      m.dpo = lit ? ~m.sdp[ix] : 1'b1;
      m.fd  = e && last;
      if (e && (m.lp || last)) begin
         m.sd = d; m.sdp = p; m.smask = k;
      end
      if (e) begin
         m.lp  = 1'b0;
         m.pos = m.pos + 1;
      end
      m.idx = (m.pos / RD) % nd;
      return m;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
   endtask

   task automatic check_inst(input string nm, input mdl_t m, input logic [7:0] a, input logic [6:0] c,
                             input logic d, input logic [2:0] ix, input logic f);
      check({nm, "_an"}, 32'(a), 32'(m.an));
      check({nm, "_cc"}, 32'(c), 32'(m.cc));
      check({nm, "_dp_out"}, 32'(d), 32'(m.dpo));
      check({nm, "_idx"}, 32'(ix), 32'(m.idx));
      check({nm, "_frame_done"}, 32'(f), 32'(m.fd));
   endtask

   task automatic step();
      @(posedge clk);
      m8 = mstep(m8, 8, en, data, dp, mask);
      m4 = mstep(m4, 4, en, data, dp, mask);
      #1;
      check_inst("d8", m8, an8, cc8, dpo8, idx8, fd8);
      check_inst("d4", m4, an4, cc4, dpo4, idx4, fd4);
   endtask

   task automatic check_dark(input string nm);
      check({nm, "_an8"}, 32'(an8), 32'hFF);
      check({nm, "_cc8"}, 32'(cc8), 32'h7F);
      check({nm, "_dp8"}, 32'(dpo8), 32'h1);
      check({nm, "_idx8"}, 32'(idx8), 32'h0);
      check({nm, "_fd8"}, 32'(fd8), 32'h0);
      check({nm, "_an4"}, 32'(an4), 32'hFF);
      check({nm, "_idx4"}, 32'(idx4), 32'h0);
   endtask

   initial begin
      bit hit;
      m8 = mreset();
      m4 = mreset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_dark("reset");
      rst = 1'b0;
      m8 = mreset();
      m4 = mreset();
      repeat (4) step();

      // Plain scan of 0..7 across several frames
      data = 32'h7654_3210; mask = 8'hFF; dp = 8'h00; en = 1'b1;
      repeat (70) step();

      // Mid-frame data change stays invisible until the next frame
      hit = 1'b0;
      for (int i = 0; i < 64 && !hit; i++) begin
         if (m8.idx == 3 && (m8.pos % RD) == 0) hit = 1'b1;
         else step();
      end
      check("reach_idx3", 32'(hit), 32'h1);
      data = 32'hFFFF_FFFF;
      repeat (40) step();

      // Partial mask and a single decimal point
      mask = 8'h0F; dp = 8'h01;
      repeat (40) step();

      // Pause mid-slot, then resume in the same slot
      mask = 8'hFF; data = 32'h89AB_CDEF;
      hit = 1'b0;
      for (int i = 0; i < 96 && !hit; i++) begin
         if (m8.idx == 5 && (m8.pos % RD) == 2) hit = 1'b1;
         else step();
      end
      check("reach_idx5_div2", 32'(hit), 32'h1);
      en = 1'b0;
      repeat (10) step();
      en = 1'b1;
      repeat (20) step();

      // Randomized inputs and enable toggling
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0) data = $urandom;
         if ($urandom_range(0, 7) == 0) dp   = 8'($urandom);
         if ($urandom_range(0, 7) == 0) mask = 8'($urandom);
         en = ($urandom_range(0, 9) != 0);
         step();
      end

      // Asynchronous reset in the middle of a lit slot
      en = 1'b1; mask = 8'hFF;
      hit = 1'b0;
      for (int i = 0; i < 96 && !hit; i++) begin
         if (m8.idx == 2 && (m8.pos % RD) == 2) hit = 1'b1;
         else step();
      end
      check("reach_midslot", 32'(hit), 32'h1);
      #2 rst = 1'b1;
      #1 check_dark("async_rst");
      repeat (2) @(posedge clk);
      #1;
      en = 1'b0; rst = 1'b0;
      m8 = mreset();
      m4 = mreset();
      repeat (3) step();
      en = 1'b1; data = 32'h0123_4567; dp = 8'h80;
      repeat (40) step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Global timeout guard
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
